// File: rtl/qtable_update_param_if.sv
// Bundle between the Q-table update engine and its surroundings: packet
// fields from the parser, neighbour/CH memory ports and engine status.
interface qtable_update_param_if #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned NB_AW      = 4,
  parameter int unsigned CH_AW      = 3
);
  // packet fields and start pulse
  logic                  en;
  logic [WORD_WIDTH-1:0] f_source_id;
  logic [WORD_WIDTH-1:0] f_source_hops;
  logic [WORD_WIDTH-1:0] f_cluster_id;
  logic [WORD_WIDTH-1:0] f_energy_left;
  logic [WORD_WIDTH-1:0] f_q_value;
  logic [WORD_WIDTH-1:0] f_known_ch;
  logic [2:0]            f_packet_type;
  // neighbour table port
  logic [NB_AW-1:0]      nb_rd_addr;
  logic [WORD_WIDTH-1:0] nb_rd_id;
  logic [WORD_WIDTH-1:0] nb_rd_q;
  logic                  nb_wr_en;
  logic [NB_AW-1:0]      nb_wr_addr;
  logic [WORD_WIDTH-1:0] nb_wr_id;
  logic [WORD_WIDTH-1:0] nb_wr_hops;
  logic [WORD_WIDTH-1:0] nb_wr_cluster;
  logic [WORD_WIDTH-1:0] nb_wr_energy;
  logic [WORD_WIDTH-1:0] nb_wr_q;
  // known-CH table port
  logic [CH_AW-1:0]      ch_rd_addr;
  logic [WORD_WIDTH-1:0] ch_rd_data;
  logic                  ch_wr_en;
  logic [CH_AW-1:0]      ch_wr_addr;
  logic [WORD_WIDTH-1:0] ch_wr_data;
  // status
  logic [NB_AW:0]        neighbor_count;
  logic [CH_AW:0]        known_ch_count;
  logic [2:0]            last_packet_type;
  logic                  busy;
  logic                  done;
  logic                  nb_overflow;
  logic                  ch_overflow;

  // environment side: parser plus memory banks
  modport master (
    output en, f_source_id, f_source_hops, f_cluster_id, f_energy_left,
           f_q_value, f_known_ch, f_packet_type, nb_rd_id, nb_rd_q, ch_rd_data,
    input  nb_rd_addr, nb_wr_en, nb_wr_addr, nb_wr_id, nb_wr_hops, nb_wr_cluster,
           nb_wr_energy, nb_wr_q, ch_rd_addr, ch_wr_en, ch_wr_addr, ch_wr_data,
           neighbor_count, known_ch_count, last_packet_type, busy, done,
           nb_overflow, ch_overflow
  );

  // engine side
  modport slave (
    input  en, f_source_id, f_source_hops, f_cluster_id, f_energy_left,
           f_q_value, f_known_ch, f_packet_type, nb_rd_id, nb_rd_q, ch_rd_data,
    output nb_rd_addr, nb_wr_en, nb_wr_addr, nb_wr_id, nb_wr_hops, nb_wr_cluster,
           nb_wr_energy, nb_wr_q, ch_rd_addr, ch_wr_en, ch_wr_addr, ch_wr_data,
           neighbor_count, known_ch_count, last_packet_type, busy, done,
           nb_overflow, ch_overflow
  );
endinterface

// File: rtl/qtable_update_param.sv
// Q-table update engine for the EER-RL clustering node: per packet, find or
// append the source in the neighbour table, then record the advertised CH.
// Optional macro QTABLE_EVICT_MIN_Q_EN: a full neighbour table evicts the
// entry with the smallest Q instead of dropping the new neighbour.
module qtable_update_param #(
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned NB_DEPTH   = 16,
  parameter int unsigned CH_DEPTH   = 8,
  parameter int unsigned NB_AW      = 4,
  parameter int unsigned CH_AW      = 3
) (
  input logic clk,
  input logic nrst,
  qtable_update_param_if.slave bus
);

  localparam int unsigned NB_CW = NB_AW + 1;
  localparam int unsigned CH_CW = CH_AW + 1;

  typedef enum logic [2:0] {
    IDLE, NB_REQ, NB_CMP, NB_WR, CH_REQ, CH_CMP, CH_WR, FIN
  } state_e;

  state_e                state_q, state_d;
  logic [NB_CW-1:0]      i_q, i_d;
  logic [CH_CW-1:0]      j_q, j_d;
  logic [NB_AW-1:0]      nb_rd_addr_q, nb_rd_addr_d;
  logic                  nb_wr_en_q, nb_wr_en_d;
  logic [NB_AW-1:0]      nb_wr_addr_q, nb_wr_addr_d;
  logic [CH_AW-1:0]      ch_rd_addr_q, ch_rd_addr_d;
  logic                  ch_wr_en_q, ch_wr_en_d;
  logic [CH_AW-1:0]      ch_wr_addr_q, ch_wr_addr_d;
  logic [NB_CW-1:0]      nb_cnt_q, nb_cnt_d;
  logic [CH_CW-1:0]      ch_cnt_q, ch_cnt_d;
  logic [2:0]            last_type_q, last_type_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  nb_ovf_q, nb_ovf_d;
  logic                  ch_ovf_q, ch_ovf_d;

  logic [WORD_WIDTH-1:0] src_q, hops_q, clus_q, energy_q, qv_q, kch_q;
  logic [2:0]            ptype_q;

`ifdef QTABLE_EVICT_MIN_Q_EN
  logic [WORD_WIDTH-1:0] min_q_q, min_q_d;
  logic [NB_AW-1:0]      min_idx_q, min_idx_d;
`endif

  // Packet fields captured on the accepted start pulse
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      src_q    <= '0;
      hops_q   <= '0;
      clus_q   <= '0;
      energy_q <= '0;
      qv_q     <= '0;
      kch_q    <= '0;
      ptype_q  <= '0;
    end else if (state_q == IDLE && bus.en) begin
      src_q    <= bus.f_source_id;
      hops_q   <= bus.f_source_hops;
      clus_q   <= bus.f_cluster_id;
      energy_q <= bus.f_energy_left;
      qv_q     <= bus.f_q_value;
      kch_q    <= bus.f_known_ch;
      ptype_q  <= bus.f_packet_type;
    end
  end

  // State, scan indices, counts and registered outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      i_q          <= '0;
      j_q          <= '0;
      nb_rd_addr_q <= '0;
      nb_wr_en_q   <= 1'b0;
      nb_wr_addr_q <= '0;
      ch_rd_addr_q <= '0;
      ch_wr_en_q   <= 1'b0;
      ch_wr_addr_q <= '0;
      nb_cnt_q     <= '0;
      ch_cnt_q     <= '0;
      last_type_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      nb_ovf_q     <= 1'b0;
      ch_ovf_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      j_q          <= j_d;
      nb_rd_addr_q <= nb_rd_addr_d;
      nb_wr_en_q   <= nb_wr_en_d;
      nb_wr_addr_q <= nb_wr_addr_d;
      ch_rd_addr_q <= ch_rd_addr_d;
      ch_wr_en_q   <= ch_wr_en_d;
      ch_wr_addr_q <= ch_wr_addr_d;
      nb_cnt_q     <= nb_cnt_d;
      ch_cnt_q     <= ch_cnt_d;
      last_type_q  <= last_type_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      nb_ovf_q     <= nb_ovf_d;
      ch_ovf_q     <= ch_ovf_d;
    end
  end

`ifdef QTABLE_EVICT_MIN_Q_EN
  // Running minimum of Q seen during the neighbour scan
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      min_q_q   <= '0;
      min_idx_q <= '0;
    end else begin
      min_q_q   <= min_q_d;
      min_idx_q <= min_idx_d;
    end
  end
`endif

  // Next state; outputs are decided one cycle ahead so they register cleanly
  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    j_d          = j_q;
    nb_rd_addr_d = nb_rd_addr_q;
    nb_wr_en_d   = 1'b0;
    nb_wr_addr_d = nb_wr_addr_q;
    ch_rd_addr_d = ch_rd_addr_q;
    ch_wr_en_d   = 1'b0;
    ch_wr_addr_d = ch_wr_addr_q;
    nb_cnt_d     = nb_cnt_q;
    ch_cnt_d     = ch_cnt_q;
    last_type_d  = last_type_q;
    nb_ovf_d     = nb_ovf_q;
    ch_ovf_d     = ch_ovf_q;
`ifdef QTABLE_EVICT_MIN_Q_EN
    min_q_d      = min_q_q;
    min_idx_d    = min_idx_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d      = NB_REQ;
          i_d          = '0;
          nb_rd_addr_d = '0;
        end
      end
      NB_REQ: begin
        if (i_q == nb_cnt_q) begin
          // scan exhausted: append
          state_d = NB_WR;
          if (nb_cnt_q < NB_CW'(NB_DEPTH)) begin
            nb_wr_en_d   = 1'b1;
            nb_wr_addr_d = NB_AW'(nb_cnt_q);
            nb_cnt_d     = nb_cnt_q + NB_CW'(1);
          end else begin
`ifdef QTABLE_EVICT_MIN_Q_EN
            nb_wr_en_d   = 1'b1;
            nb_wr_addr_d = min_idx_q;
`else
            nb_ovf_d     = 1'b1;
`endif
          end
        end else begin
          state_d = NB_CMP;
        end
      end
      NB_CMP: begin
        if (bus.nb_rd_id == src_q) begin
          state_d      = NB_WR;
          nb_wr_en_d   = 1'b1;
          nb_wr_addr_d = NB_AW'(i_q);
        end else begin
`ifdef QTABLE_EVICT_MIN_Q_EN
          // strict less-than keeps the lowest index on ties
          if (i_q == '0 || bus.nb_rd_q < min_q_q) begin
            min_q_d   = bus.nb_rd_q;
            min_idx_d = NB_AW'(i_q);
          end
`endif
          state_d      = NB_REQ;
          i_d          = i_q + NB_CW'(1);
          nb_rd_addr_d = NB_AW'(i_q + NB_CW'(1));
        end
      end
      NB_WR: begin
        if (kch_q != '0) begin
          state_d      = CH_REQ;
          j_d          = '0;
          ch_rd_addr_d = '0;
        end else begin
          state_d = FIN;
        end
      end
      CH_REQ: begin
        if (j_q == ch_cnt_q) begin
          state_d = CH_WR;
          if (ch_cnt_q < CH_CW'(CH_DEPTH)) begin
            ch_wr_en_d   = 1'b1;
            ch_wr_addr_d = CH_AW'(ch_cnt_q);
            ch_cnt_d     = ch_cnt_q + CH_CW'(1);
          end else begin
            ch_ovf_d = 1'b1;
          end
        end else begin
          state_d = CH_CMP;
        end
      end
      CH_CMP: begin
        if (bus.ch_rd_data == kch_q) begin
          state_d = FIN;
        end else begin
          state_d      = CH_REQ;
          j_d          = j_q + CH_CW'(1);
          ch_rd_addr_d = CH_AW'(j_q + CH_CW'(1));
        end
      end
      CH_WR:   state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
    if (state_d == FIN) begin
      last_type_d = ptype_q;
    end
  end

  // Output mapping; write data comes straight from the stable latched fields
  assign bus.nb_rd_addr       = nb_rd_addr_q;
  assign bus.nb_wr_en         = nb_wr_en_q;
  assign bus.nb_wr_addr       = nb_wr_addr_q;
  assign bus.nb_wr_id         = src_q;
  assign bus.nb_wr_hops       = hops_q;
  assign bus.nb_wr_cluster    = clus_q;
  assign bus.nb_wr_energy     = energy_q;
  assign bus.nb_wr_q          = qv_q;
  assign bus.ch_rd_addr       = ch_rd_addr_q;
  assign bus.ch_wr_en         = ch_wr_en_q;
  assign bus.ch_wr_addr       = ch_wr_addr_q;
  assign bus.ch_wr_data       = kch_q;
  assign bus.neighbor_count   = nb_cnt_q;
  assign bus.known_ch_count   = ch_cnt_q;
  assign bus.last_packet_type = last_type_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.nb_overflow      = nb_ovf_q;
  assign bus.ch_overflow      = ch_ovf_q;

endmodule

// File: tb/tb_qtable_update_param.sv
// Directed bench for qtable_update_param with behavioural neighbour/CH memories.
module tb_qtable_update_param;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  qtable_update_param_if #(.WORD_WIDTH(16), .NB_AW(4), .CH_AW(3)) bus();

  qtable_update_param #(
    .WORD_WIDTH(16), .NB_DEPTH(16), .CH_DEPTH(8), .NB_AW(4), .CH_AW(3)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  // memory banks: synchronous read, one-cycle latency
  logic [15:0] nb_id_mem [16];
  logic [15:0] nb_q_mem  [16];
  logic [15:0] ch_mem    [8];

  initial begin
    for (int k = 0; k < 16; k++) begin nb_id_mem[k] = '0; nb_q_mem[k] = '0; end
    for (int k = 0; k < 8; k++) ch_mem[k] = '0;
  end

  always @(posedge clk) begin
    bus.nb_rd_id   <= nb_id_mem[bus.nb_rd_addr];
    bus.nb_rd_q    <= nb_q_mem[bus.nb_rd_addr];
    bus.ch_rd_data <= ch_mem[bus.ch_rd_addr];
    if (bus.nb_wr_en) begin
      nb_id_mem[bus.nb_wr_addr] <= bus.nb_wr_id;
      nb_q_mem[bus.nb_wr_addr]  <= bus.nb_wr_q;
    end
    if (bus.ch_wr_en) ch_mem[bus.ch_wr_addr] <= bus.ch_wr_data;
  end

  // strobe monitor, sampled mid-cycle
  int nb_wr_cnt = 0, ch_wr_cnt = 0, done_cnt = 0;
  logic [15:0] nb_l_addr, nb_l_id, nb_l_hops, nb_l_cl, nb_l_en, nb_l_q, ch_l_addr, ch_l_data;
  always @(negedge clk) begin
    if (bus.nb_wr_en) begin
      nb_wr_cnt++;
      nb_l_addr = 16'(bus.nb_wr_addr);
      nb_l_id   = bus.nb_wr_id;
      nb_l_hops = bus.nb_wr_hops;
      nb_l_cl   = bus.nb_wr_cluster;
      nb_l_en   = bus.nb_wr_energy;
      nb_l_q    = bus.nb_wr_q;
    end
    if (bus.ch_wr_en) begin
      ch_wr_cnt++;
      ch_l_addr = 16'(bus.ch_wr_addr);
      ch_l_data = bus.ch_wr_data;
    end
    if (bus.done) done_cnt++;
  end

  int checks = 0;
  int failures = 0;
  int nb0, ch0, dn0, cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_fields(input logic [15:0] id, hops, cl, energy, q, kch,
                              input logic [2:0] pt);
    bus.f_source_id   = id;
    bus.f_source_hops = hops;
    bus.f_cluster_id  = cl;
    bus.f_energy_left = energy;
    bus.f_q_value     = q;
    bus.f_known_ch    = kch;
    bus.f_packet_type = pt;
  endtask

  // one-cycle en pulse, then count cycles until done (bounded)
  task automatic run_op(input logic [15:0] id, hops, cl, energy, q, kch,
                        input logic [2:0] pt, output int c);
    @(negedge clk);
    drive_fields(id, hops, cl, energy, q, kch, pt);
    nb0 = nb_wr_cnt; ch0 = ch_wr_cnt;
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    c = 1;
    while (!bus.done && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (!bus.done) check("done_timeout", 32'(c), 32'd0);
  endtask

  initial begin
    bus.en = 1'b0;
    drive_fields('0, '0, '0, '0, '0, '0, '0);
    repeat (3) @(negedge clk);
    check("rst_nb_count", 32'(bus.neighbor_count), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    nrst = 1'b1;

    // T1: empty tables, new neighbour and new CH
    run_op(16'd1, 16'd2, 16'd2, 16'h8000, 16'h3000, 16'd15, 3'd1, cyc);
    check("t1_cycles", 32'(cyc), 32'd5);
    check("t1_nb_strobes", 32'(nb_wr_cnt - nb0), 32'd1);
    check("t1_nb_addr", 32'(nb_l_addr), 32'd0);
    check("t1_nb_id", 32'(nb_l_id), 32'd1);
    check("t1_nb_hops", 32'(nb_l_hops), 32'd2);
    check("t1_nb_cluster", 32'(nb_l_cl), 32'd2);
    check("t1_nb_energy", 32'(nb_l_en), 32'h8000);
    check("t1_nb_q", 32'(nb_l_q), 32'h3000);
    check("t1_ch_strobes", 32'(ch_wr_cnt - ch0), 32'd1);
    check("t1_ch_addr", 32'(ch_l_addr), 32'd0);
    check("t1_ch_data", 32'(ch_l_data), 32'd15);
    check("t1_nb_count", 32'(bus.neighbor_count), 32'd1);
    check("t1_ch_count", 32'(bus.known_ch_count), 32'd1);
    check("t1_ptype", 32'(bus.last_packet_type), 32'd1);

    // T2: same source updates in place, CH already known
    run_op(16'd1, 16'd2, 16'd2, 16'h8000, 16'h2000, 16'd15, 3'd2, cyc);
    check("t2_cycles", 32'(cyc), 32'd6);
    check("t2_nb_strobes", 32'(nb_wr_cnt - nb0), 32'd1);
    check("t2_nb_addr", 32'(nb_l_addr), 32'd0);
    check("t2_nb_q", 32'(nb_l_q), 32'h2000);
    check("t2_ch_strobes", 32'(ch_wr_cnt - ch0), 32'd0);
    check("t2_nb_count", 32'(bus.neighbor_count), 32'd1);
    check("t2_ch_count", 32'(bus.known_ch_count), 32'd1);

    // T3: second neighbour, no CH advertised
    run_op(16'd17, 16'd3, 16'd4, 16'h7000, 16'h1000, 16'd0, 3'd3, cyc);
    check("t3_cycles", 32'(cyc), 32'd5);
    check("t3_nb_addr", 32'(nb_l_addr), 32'd1);
    check("t3_nb_id", 32'(nb_l_id), 32'd17);
    check("t3_ch_strobes", 32'(ch_wr_cnt - ch0), 32'd0);
    check("t3_nb_count", 32'(bus.neighbor_count), 32'd2);

    // T4: update id 1 (first entry), CH 20 appended after scanning CH 15
    run_op(16'd1, 16'd2, 16'd2, 16'h8000, 16'h2000, 16'd20, 3'd4, cyc);
    check("t4_cycles", 32'(cyc), 32'd8);
    check("t4_nb_addr", 32'(nb_l_addr), 32'd0);
    check("t4_ch_addr", 32'(ch_l_addr), 32'd1);
    check("t4_ch_data", 32'(ch_l_data), 32'd20);
    check("t4_ch_count", 32'(bus.known_ch_count), 32'd2);

    // fill the neighbour table; the entry at address 7 carries the smallest Q
    for (int k = 0; k < 14; k++) begin
      run_op(16'(100 + k), 16'd1, 16'd1, 16'd1, (k == 5) ? 16'h0010 : 16'h5000,
             16'd0, 3'd5, cyc);
      check("fill_nb_addr", 32'(nb_l_addr), 32'(2 + k));
    end
    check("fill_nb_count", 32'(bus.neighbor_count), 32'd16);

    // T5: new ID into a full table
    run_op(16'd200, 16'd9, 16'd9, 16'd9, 16'h4444, 16'd0, 3'd6, cyc);
    check("t5_cycles", 32'(cyc), 32'd35);
    check("t5_nb_count", 32'(bus.neighbor_count), 32'd16);
`ifdef QTABLE_EVICT_MIN_Q_EN
    check("t5_nb_strobes", 32'(nb_wr_cnt - nb0), 32'd1);
    check("t5_evict_addr", 32'(nb_l_addr), 32'd7);
    check("t5_evict_id", 32'(nb_l_id), 32'd200);
    check("t5_nb_overflow", 32'(bus.nb_overflow), 32'd0);
`else
    check("t5_nb_strobes", 32'(nb_wr_cnt - nb0), 32'd0);
    check("t5_nb_overflow", 32'(bus.nb_overflow), 32'd1);
`endif

    // T6: reset while comparing the first neighbour entry
    @(negedge clk);
    drive_fields(16'd300, 16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 3'd7);
    nb0 = nb_wr_cnt; ch0 = ch_wr_cnt;
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    @(negedge clk);
    check("t6_busy_before", 32'(bus.busy), 32'd1);
    nrst = 1'b0;
    #1;
    check("t6_busy", 32'(bus.busy), 32'd0);
    check("t6_nb_count", 32'(bus.neighbor_count), 32'd0);
    check("t6_ch_count", 32'(bus.known_ch_count), 32'd0);
    check("t6_nb_overflow", 32'(bus.nb_overflow), 32'd0);
    check("t6_nb_rd_addr", 32'(bus.nb_rd_addr), 32'd0);
    check("t6_nb_wr_addr", 32'(bus.nb_wr_addr), 32'd0);
    check("t6_nb_wr_id", 32'(bus.nb_wr_id), 32'd0);
    check("t6_ch_wr_data", 32'(bus.ch_wr_data), 32'd0);
    check("t6_ptype", 32'(bus.last_packet_type), 32'd0);
    repeat (3) @(negedge clk);
    check("t6_no_writes", 32'(nb_wr_cnt - nb0 + ch_wr_cnt - ch0), 32'd0);
    nrst = 1'b1;

    run_op(16'd5, 16'd1, 16'd1, 16'd1, 16'h0100, 16'd9, 3'd7, cyc);
    check("t6_cycles", 32'(cyc), 32'd5);
    check("t6_nb_addr_after", 32'(nb_l_addr), 32'd0);
    check("t6_ch_addr_after", 32'(ch_l_addr), 32'd0);
    check("t6_ch_data_after", 32'(ch_l_data), 32'd9);
    check("t6_nb_count_after", 32'(bus.neighbor_count), 32'd1);
    check("t6_ch_count_after", 32'(bus.known_ch_count), 32'd1);

    // T7: en held for three cycles gives exactly one operation
    @(negedge clk);
    drive_fields(16'd6, 16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 3'd2);
    nb0 = nb_wr_cnt; dn0 = done_cnt;
    bus.en = 1'b1;
    repeat (3) @(negedge clk);
    bus.en = 1'b0;
    repeat (20) @(negedge clk);
    check("t7_done_pulses", 32'(done_cnt - dn0), 32'd1);
    check("t7_nb_strobes", 32'(nb_wr_cnt - nb0), 32'd1);
    check("t7_nb_addr", 32'(nb_l_addr), 32'd1);
    check("t7_nb_count", 32'(bus.neighbor_count), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
